signal_generator_top: RTL and testbench



---
 rtl/siggen_pkg.sv | 37 +++
 rtl/signal_memory.sv | 27 ++
 rtl/signal_generator_top.sv | 106 ++++++++++
 tb/tb_signal_generator_top.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/siggen_pkg.sv
// siggen_pkg: shared constants, 7-segment lookup and sine table generator for the signal generator
package siggen_pkg;

    localparam int ROM_DEPTH = 1024;
    localparam int ADDR_W    = 10;
    localparam int SAMPLE_W  = 16;
    localparam int DIV_W     = 8;

    // Active-low segments, bit0 = seg a, indexed by hex digit 0..F
    localparam logic [0:15][6:0] SEG7 = {
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // One sine period in offset binary (0x8000 = midscale, amplitude 32767).
    // Folded onto the first quarter wave and evaluated with a Taylor series
    // to x^15, accurate far below one LSB, so no math library is needed.
    function automatic logic [SAMPLE_W-1:0] sine_at(input int i);
        int  j;
        int  mag;
        real x;
        real t;
        real s;
        j = i % 512;
        if (j > 256) j = 512 - j;
        x = $itor(j) * 3.14159265358979 / 512.0;
        t = x;
        s = x;
        for (int k = 1; k < 8; k++) begin
            t = -t * x * x / $itor((2 * k) * (2 * k + 1));
            s = s + t;
        end
        mag = $rtoi(32767.0 * s + 0.5);
        return i < 512 ? 16'(32768 + mag) : 16'(32768 - mag);
    endfunction

endpackage

// File: rtl/signal_memory.sv
// signal_memory: 1024x16 sine ROM with registered address and unregistered output (altsyncram-equivalent)
module signal_memory
    import siggen_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   address,
    output logic [SAMPLE_W-1:0] q
);

    logic [SAMPLE_W-1:0] rom [ROM_DEPTH];
    logic [ADDR_W-1:0]   addr_q;

    for (genvar i = 0; i < ROM_DEPTH; i++) begin : g_rom
        localparam logic [SAMPLE_W-1:0] V = sine_at(i);
        assign rom[i] = V;
    end

    // Address register; cleared on reset so the first read after reset is entry 0
    always_ff @(posedge clk or negedge rst_n) begin : altsyncram_component
        if (!rst_n) addr_q <= '0;
        else        addr_q <= address;
    end

    assign q = rom[addr_q];

endmodule

// File: rtl/signal_generator_top.sv
// signal_generator_top: button-controlled DDS sine generator driving a GPIO DAC, LEDs and HEX displays
module signal_generator_top
    import siggen_pkg::*;
(
    input  logic        CLOCK_125_p,
    input  logic        CLOCK_50_B5B,
    input  logic        CLOCK_50_B6A,
    input  logic        CLOCK_50_B7A,
    input  logic        CLOCK_50_B8A,
    input  logic        CPU_RESET_n,
    input  logic [3:0]  KEY,
    input  logic [9:0]  SW,
    output logic [7:0]  LEDG,
    output logic [9:0]  LEDR,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    inout  wire  [35:0] GPIO
);

    logic                clk;
    logic                rst_n;
    logic [1:0]          key_s1_q, key_s1_d;
    logic [1:0]          key_s2_q, key_s2_d;
    logic [1:0]          key_s3_q, key_s3_d;
    logic                sw_up_q, sw_up_d;
    logic                sw_down_q, sw_down_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [DIV_W-1:0]    cnt_q, cnt_d;
    logic                inc_data_q, inc_data_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [2:0]          stb_q, stb_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic [SAMPLE_W-1:0] rom_q;
    logic                div_chg;
    logic                sw_up;
    logic                sw_down;
    logic                inc_data;
    logic                unused_inputs;

    assign clk      = CLOCK_50_B5B;
    assign rst_n    = CPU_RESET_n;
    assign sw_up    = sw_up_q;
    assign sw_down  = sw_down_q;
    assign inc_data = inc_data_q;

    // Key sync/edge detect, saturating rate register, rate counter, phase counter and output pipe
    always_comb begin
        key_s1_d   = KEY[1:0];
        key_s2_d   = key_s1_q;
        key_s3_d   = key_s2_q;
        sw_up_d    = key_s2_q[0] & ~key_s3_q[0];
        sw_down_d  = key_s2_q[1] & ~key_s3_q[1];
        div_d      = (sw_down_q && !sw_up_q && div_q != '1) ? div_q + 1'b1 :
                     (sw_up_q && !sw_down_q && div_q != '0) ? div_q - 1'b1 : div_q;
        div_chg    = div_d != div_q;
        inc_data_d = !div_chg && cnt_q == div_q;
        cnt_d      = (div_chg || cnt_q == div_q) ? '0 : cnt_q + 1'b1;
        addr_d     = addr_q + ADDR_W'(inc_data_q);
        stb_d      = {stb_q[1:0], inc_data_q};
        sample_d   = rom_q;
    end

    // State registers; the strobe pipe matches address, ROM and sample register stages
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_s1_q   <= '0;
            key_s2_q   <= '0;
            key_s3_q   <= '0;
            sw_up_q    <= 1'b0;
            sw_down_q  <= 1'b0;
            div_q      <= '0;
            cnt_q      <= '0;
            inc_data_q <= 1'b0;
            addr_q     <= '0;
            stb_q      <= '0;
            sample_q   <= '0;
        end else begin
            key_s1_q   <= key_s1_d;
            key_s2_q   <= key_s2_d;
            key_s3_q   <= key_s3_d;
            sw_up_q    <= sw_up_d;
            sw_down_q  <= sw_down_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            inc_data_q <= inc_data_d;
            addr_q     <= addr_d;
            stb_q      <= stb_d;
            sample_q   <= sample_d;
        end
    end

    signal_memory u0_signal_memory (
        .clk     (clk),
        .rst_n   (rst_n),
        .address (addr_q),
        .q       (rom_q)
    );

    assign LEDG          = sample_q[15:8];
    assign LEDR          = {2'b00, div_q};
    assign HEX0          = SEG7[div_q[3:0]];
    assign HEX1          = SEG7[div_q[7:4]];
    assign GPIO          = {19'b0, stb_q[2], sample_q};
    assign unused_inputs = ^{CLOCK_125_p, CLOCK_50_B6A, CLOCK_50_B7A, CLOCK_50_B8A, KEY[3:2], SW};

endmodule

// File: tb/tb_signal_generator_top.sv
// tb_signal_generator_top: directed self-checking bench for the sine signal generator
module tb_signal_generator_top;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  key;
    logic [9:0]  sw;
    logic [7:0]  ledg;
    logic [9:0]  ledr;
    logic [6:0]  hex0;
    logic [6:0]  hex1;
    wire  [35:0] gpio;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    signal_generator_top dut (
        .CLOCK_125_p  (1'b0),
        .CLOCK_50_B5B (clk),
        .CLOCK_50_B6A (1'b0),
        .CLOCK_50_B7A (1'b0),
        .CLOCK_50_B8A (1'b0),
        .CPU_RESET_n  (rst_n),
        .KEY          (key),
        .SW           (sw),
        .LEDG         (ledg),
        .LEDR         (ledr),
        .HEX0         (hex0),
        .HEX1         (hex1),
        .GPIO         (gpio)
    );

    function automatic int rom_exp(input int i);
        real s;
        s = $sin(2.0 * 3.14159265358979 * $itor(i) / 1024.0);
        return s >= 0.0 ? 32768 + $rtoi(32767.0 * s + 0.5) : 32768 - $rtoi(-32767.0 * s + 0.5);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_near(input string tag, input logic [15:0] obs, input int exp);
        checks++;
        assert (!$isunknown(obs) && int'(obs) - exp <= 1 && exp - int'(obs) <= 1) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input int b, input int n);
        repeat (n) begin
            key[b] = 1'b1;
            tick(2);
            key[b] = 1'b0;
            tick(2);
        end
    endtask

    task automatic period(input string tag, input int exp);
        int n;
        n = 0;
        while (dut.inc_data !== 1'b1 && n < 600) begin
            tick(1);
            n++;
        end
        chk({tag, "_pulse_seen"}, 32'(n < 600), 1);
        tick(1);
        n = 1;
        while (dut.inc_data !== 1'b1 && n < 600) begin
            tick(1);
            n++;
        end
        chk(tag, n, exp);
    endtask

    task automatic count(input string tag, input int cycles, input int exp);
        int c;
        c = 0;
        repeat (cycles) begin
            tick(1);
            if (dut.inc_data === 1'b1) c++;
        end
        chk(tag, c, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ledg"}, ledg, 0);
        chk({tag, "_ledr"}, ledr, 0);
        chk({tag, "_gpio"}, gpio, 0);
        chk({tag, "_hex0"}, hex0, 7'b1000000);
        chk({tag, "_hex1"}, hex1, 7'b1000000);
        chk({tag, "_inc"}, dut.inc_data, 0);
        chk({tag, "_swup"}, dut.sw_up, 0);
        chk({tag, "_swdn"}, dut.sw_down, 0);
    endtask

    // Releases reset at the current point and follows the div=0 stream for n clocks:
    // after clock k the sample holds ROM[k-3] (ROM[0] before that) and the strobe rises from clock 4.
    task automatic run_from_reset(input int n);
        int idx;
        rst_n = 1'b1;
        for (int k = 1; k <= n; k++) begin
            tick(1);
            idx = k > 3 ? (k - 3) % 1024 : 0;
            chk("inc_every_clk", dut.inc_data, 1);
            chk("strobe", gpio[16], 32'(k >= 4));
            chk_near("sample", gpio[15:0], rom_exp(idx));
            if (idx == 0 && k > 3) begin
                chk("wrap_sample", gpio[15:0], 16'h8000);
                chk("wrap_ledg", ledg, 8'h80);
            end
            if (idx == 256) chk("peak_sample", gpio[15:0], 16'hFFFF);
            if (idx == 768) chk("trough_sample", gpio[15:0], 16'h0001);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        key   = 4'b0000;
        sw    = 10'b0;
        tick(3);
        check_reset_outputs("reset");
        run_from_reset(12);

        key[1] = 1'b1;
        tick(3);
        chk("sw_down_pulse", dut.sw_down, 1);
        chk("div_before_update", ledr, 0);
        tick(1);
        chk("sw_down_single", dut.sw_down, 0);
        chk("div_after_update", ledr, 1);
        key[1] = 1'b0;
        tick(2);
        press(1, 19);
        chk("div20_ledr", ledr, 20);
        chk("div20_hex1", hex1, 7'b1111001);
        chk("div20_hex0", hex0, 7'b0011001);
        period("period_div20", 21);
        tick(1);
        chk("pulse_width_div20", dut.inc_data, 0);
        count("pulses_div20", 210, 10);

        press(0, 10);
        chk("div10_ledr", ledr, 10);
        chk("div10_hex1", hex1, 7'b1000000);
        chk("div10_hex0", hex0, 7'b0001000);
        period("period_div10", 11);
        count("pulses_div10", 220, 20);

        key[1:0] = 2'b11;
        tick(3);
        chk("both_swup", dut.sw_up, 1);
        chk("both_swdn", dut.sw_down, 1);
        tick(1);
        chk("both_div_unchanged", ledr, 10);
        key[1:0] = 2'b00;
        tick(2);
        chk("both_div_settled", ledr, 10);

        press(1, 300);
        chk("sat_hi_ledr", ledr, 255);
        chk("sat_hi_hex1", hex1, 7'b0001110);
        chk("sat_hi_hex0", hex0, 7'b0001110);
        period("period_div255", 256);

        press(0, 300);
        chk("sat_lo_ledr", ledr, 0);
        chk("sat_lo_hex0", hex0, 7'b1000000);
        period("period_div0", 1);

        press(1, 3);
        chk("div3_ledr", ledr, 3);
        tick(50);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrun_reset");
        tick(2);
        check_reset_outputs("midrun_held");
        run_from_reset(1030);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
